sobel_frame_ctrl: RTL and testbench

//  Frame sequencer for the 3x3 Sobel stage between the grayscale input FIFO and the output FIFO.

---
 rtl/sobel_frame_ctrl_pkg.sv | 27 ++
 rtl/sobel_frame_ctrl_pos.sv | 55 +++++
 rtl/sobel_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared types for the Sobel frame sequencer.
// State encoding and the per-cycle strobe bundle.
package sobel_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic shift;
    logic rd;
    logic wr;
    logic pad;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{
    shift: 1'b0,
    rd:    1'b0,
    wr:    1'b0,
    pad:   1'b0
  };

endpackage

// File: rtl/sobel_frame_ctrl_pos.sv
// Output pixel position counter for the Sobel sequencer.
// Column/row with wrap, plus frame-edge and last-pixel flags.
module sobel_frame_ctrl_pos #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int CNT_W  = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic border_o,
  output logic last_o
);

  localparam logic [CNT_W-1:0] COL_END = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_END = CNT_W'(HEIGHT - 1);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             col_wrap;

  assign col_wrap = (col_q == COL_END);

  // Next position: column wraps, then row advances.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (en_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_END) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  // Position registers, cleared at frame start.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign border_o = (col_q == '0) | col_wrap
                  | (row_q == '0) | (row_q == ROW_END);

  assign last_o = col_wrap & (row_q == ROW_END);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel stage.
// Primes the window, streams, pads the tail, flags borders.
module sobel_frame_ctrl
  import sobel_frame_ctrl_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int CNT_W  = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic fifo_in_empty,
  output logic fifo_in_rd_en,
  input  logic fifo_out_full,
  output logic fifo_out_wr_en,
  output logic win_shift_en,
  output logic win_pad,
  output logic out_border,
  output logic busy,
  output logic frame_done
);

  localparam int N         = WIDTH * HEIGHT;
  localparam int PRIME_LEN = WIDTH + 2;
  localparam int FLUSH_LEN = WIDTH + 2;

  localparam logic [CNT_W-1:0] PRIME_END =
    CNT_W'(PRIME_LEN - 1);
  localparam logic [CNT_W-1:0] READ_END =
    CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] SHIFT_END =
    CNT_W'(N + FLUSH_LEN - 1);

  state_e           state_q;
  logic [CNT_W-1:0] shift_cnt_q;
  logic [CNT_W-1:0] shift_cnt_d;
  strobe_t          stb;
  logic             pos_clr;
  logic             pos_border;
  logic             pos_last;
  logic             flush_end;

  assign shift_cnt_d = shift_cnt_q + CNT_W'(1);

  // The last pad shift must also be the last output pixel.
  assign flush_end = (shift_cnt_q == SHIFT_END) & pos_last;

  // Strobe decode: a stall leaves every strobe low.
  always_comb begin
    stb = STROBE_IDLE;
    unique case (state_q)
      S_PRIME: begin
        stb.shift = ~fifo_in_empty;
        stb.rd    = stb.shift;
      end
      S_RUN: begin
        stb.shift = ~fifo_in_empty & ~fifo_out_full;
        stb.rd    = stb.shift;
        stb.wr    = stb.shift;
      end
      S_FLUSH: begin
        stb.shift = ~fifo_out_full;
        stb.wr    = stb.shift;
        stb.pad   = stb.shift;
      end
      default: stb = STROBE_IDLE;
    endcase
  end

  // Frame FSM and shift counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_PRIME;
            shift_cnt_q <= '0;
          end
        end
        S_PRIME: begin
          if (stb.shift) begin
            shift_cnt_q <= shift_cnt_d;
            if (shift_cnt_q == PRIME_END)
              state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (stb.shift) begin
            shift_cnt_q <= shift_cnt_d;
            if (shift_cnt_q == READ_END)
              state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (stb.shift) begin
            shift_cnt_q <= shift_cnt_d;
            if (flush_end)
              state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pos_clr = (state_q == S_IDLE) & start;

  sobel_frame_ctrl_pos #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CNT_W  (CNT_W)
  ) u_pos (
    .clk_i    (clock),
    .rst_i    (reset),
    .clr_i    (pos_clr),
    .en_i     (stb.wr),
    .border_o (pos_border),
    .last_o   (pos_last)
  );

  assign fifo_in_rd_en  = stb.rd;
  assign fifo_out_wr_en = stb.wr;
  assign win_shift_en   = stb.shift;
  assign win_pad        = stb.pad;
  assign out_border     = stb.wr & pos_border;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl at WIDTH=4, HEIGHT=3.
// Shift-count model plus a write scoreboard.
module tb_sobel_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int CW = 20;

  typedef struct packed {
    logic border;
    logic pad;
  } exp_t;

  logic clock;
  logic reset;
  logic start;
  logic fifo_in_empty;
  logic fifo_in_rd_en;
  logic fifo_out_full;
  logic fifo_out_wr_en;
  logic win_shift_en;
  logic win_pad;
  logic out_border;
  logic busy;
  logic frame_done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  bit   armed = 0;
  int   m_phase = 0;
  int   m_s = 0;
  bit   e_sh, e_rd, e_wr, e_pd;
  exp_t got;

  sobel_frame_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H),
    .CNT_W  (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_out_full  (fifo_out_full),
    .fifo_out_wr_en (fifo_out_wr_en),
    .win_shift_en   (win_shift_en),
    .win_pad        (win_pad),
    .out_border     (out_border),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic exp_t pix_exp(input int j);
    exp_t e;
    int r, c;
    r = j / W;
    c = j % W;
    e.border = (r == 0) || (r == H - 1) ||
               (c == 0) || (c == W - 1);
    e.pad = (j >= N - W - 2);
    return e;
  endfunction

  // Reference model: frame progress as a shift count.
  always @(negedge clock) begin
    e_sh = 0;
    e_rd = 0;
    e_wr = 0;
    e_pd = 0;
    if (armed) begin
      if (m_phase == 1) begin
        if (m_s < W + 2)
          e_sh = !fifo_in_empty;
        else if (m_s < N)
          e_sh = !fifo_in_empty && !fifo_out_full;
        else
          e_sh = !fifo_out_full;
        e_rd = e_sh && (m_s < N);
        e_wr = e_sh && (m_s >= W + 2);
        e_pd = e_sh && (m_s >= N);
      end
      chk("rd_en", int'(fifo_in_rd_en), int'(e_rd));
      chk("wr_en", int'(fifo_out_wr_en), int'(e_wr));
      chk("shift", int'(win_shift_en), int'(e_sh));
      chk("pad", int'(win_pad), int'(e_pd));
      chk("busy", int'(busy), int'(m_phase != 0));
      chk("done", int'(frame_done), int'(m_phase == 2));
      if (!e_wr)
        chk("border_idle", int'(out_border), 0);
    end
    if (reset) begin
      armed = 1;
      m_phase = 0;
    end else if (armed) begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_s = 0;
          for (int j = 0; j < N; j++)
            sb_q.push_back(pix_exp(j));
        end
        1: if (e_sh) begin
          m_s++;
          if (m_s == N + W + 2)
            m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // An aborted frame leaves no pending writes.
  always @(posedge clock) begin
    if (reset)
      sb_q.delete();
  end

  // Monitor: pop one expectation per output write.
  always @(negedge clock) begin
    if (armed) begin
      chk("rd_while_empty",
          int'(fifo_in_rd_en && fifo_in_empty), 0);
      chk("wr_while_full",
          int'(fifo_out_wr_en && fifo_out_full), 0);
      if (fifo_in_rd_en)
        rd_cnt++;
      if (fifo_out_wr_en) begin
        wr_cnt++;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          got = sb_q.pop_front();
          chk("sb_border", int'(out_border),
              int'(got.border));
          chk("sb_pad", int'(win_pad), int'(got.pad));
        end
      end
      if (frame_done) begin
        done_cnt++;
        chk("sb_drain", sb_q.size(), 0);
      end
    end
  end

  task automatic run_frame(input int mode,
                           input int exp_lat);
    int  c;
    bit  fin;
    rd_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    fifo_in_empty = 0;
    fifo_out_full = 0;
    start = 1;
    @(posedge clock);
    #1;
    start = 0;
    fin = 0;
    c = 1;
    while (!fin && c <= 400) begin
      start = (mode == 5) && (c == 5 || c == 19);
      case (mode)
        1: fifo_in_empty = (c >= 3 && c <= 5);
        3: fifo_in_empty = ($urandom_range(0, 2) == 0);
        default: fifo_in_empty = 0;
      endcase
      case (mode)
        2: fifo_out_full =
             (c == 8 || c == 9 || c == 16 || c == 17);
        3: fifo_out_full = ($urandom_range(0, 2) == 0);
        default: fifo_out_full = 0;
      endcase
      reset = (mode == 4) && (c == 15);
      @(posedge clock);
      #1;
      if (mode == 4 && c == 15) begin
        chk("rst_rd", int'(fifo_in_rd_en), 0);
        chk("rst_wr", int'(fifo_out_wr_en), 0);
        chk("rst_shift", int'(win_shift_en), 0);
        chk("rst_pad", int'(win_pad), 0);
        chk("rst_border", int'(out_border), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        reset = 0;
        fin = 1;
      end else if (!busy) begin
        fin = 1;
        if (exp_lat > 0)
          chk("latency", c, exp_lat);
      end
      c++;
    end
    start = 0;
    fifo_in_empty = 0;
    fifo_out_full = 0;
    if (!fin)
      chk("timeout", 1, 0);
    if (mode != 4) begin
      chk("writes", wr_cnt, N);
      chk("reads", rd_cnt, N);
      chk("frame_done_cnt", done_cnt, 1);
    end
    if (mode == 5) begin
      repeat (3) @(posedge clock);
      #1;
      chk("no_restart_busy", int'(busy), 0);
      chk("no_restart_done", done_cnt, 1);
    end
  endtask

  initial begin
    reset = 1;
    start = 0;
    fifo_in_empty = 0;
    fifo_out_full = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(frame_done), 0);
    chk("reset_rd", int'(fifo_in_rd_en), 0);
    chk("reset_shift", int'(win_shift_en), 0);
    @(posedge clock);
    #1;
    run_frame(0, 19);
    run_frame(0, 19);
    run_frame(1, 22);
    run_frame(2, 23);
    run_frame(4, 0);
    @(posedge clock);
    #1;
    run_frame(0, 19);
    run_frame(5, 19);
    for (int i = 0; i < 4; i++)
      run_frame(3, 0);
    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
